// File: rtl/call_stack_unit_if.sv
// Decoder/datapath-facing bundle for the hardware call stack.
// The master drives the strobes; the slave (the stack) returns the top entry and status.
interface call_stack_unit_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SP_W   = 5
);
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;
    logic              err_clr;
    logic [DATA_W-1:0] top_data;
    logic [SP_W-1:0]   sp;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, push_data, err_clr,
        input  top_data, sp, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, push_data, err_clr,
        output top_data, sp, empty, full, overflow, underflow
    );
endinterface

// File: rtl/call_stack_unit.sv
// Saturating hardware LIFO for return addresses and pushed registers.
// Top of stack is read combinationally so a pop can be consumed in the same cycle.
module call_stack_unit #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned SP_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    call_stack_unit_if.slave   bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [SP_W-1:0]   r_sp;
    logic              r_ovf;
    logic              r_unf;

    logic [SP_W-1:0]   w_sp_d;
    logic              w_ovf_d;
    logic              w_unf_d;
    logic              w_we;
    logic [IDX_W-1:0]  w_waddr;
    logic [IDX_W-1:0]  w_top_idx;
    logic              w_empty;
    logic              w_full;

    assign w_empty   = (r_sp == '0);
    assign w_full    = (r_sp == SP_W'(DEPTH));
    assign w_top_idx = IDX_W'(r_sp - SP_W'(1));

    always_comb begin
        w_sp_d  = r_sp;
        w_we    = 1'b0;
        w_waddr = r_sp[IDX_W-1:0];
        // Clear first so an error event in the same cycle wins
        w_ovf_d = r_ovf & ~bus.err_clr;
        w_unf_d = r_unf & ~bus.err_clr;
        case ({bus.push, bus.pop})
            2'b10: begin
                if (!w_full) begin
                    w_we   = 1'b1;
                    w_sp_d = r_sp + SP_W'(1);
                end else begin
                    w_ovf_d = 1'b1;
                end
            end
            2'b01: begin
                if (!w_empty) begin
                    w_sp_d = r_sp - SP_W'(1);
                end else begin
                    w_unf_d = 1'b1;
                end
            end
            2'b11: begin
                w_we = 1'b1;
                if (!w_empty) begin
                    w_waddr = w_top_idx;
                end else begin
                    // Replace on an empty stack degrades to a plain push
                    w_waddr = '0;
                    w_sp_d  = SP_W'(1);
                    w_unf_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp  <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_sp  <= w_sp_d;
            r_ovf <= w_ovf_d;
            r_unf <= w_unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= bus.push_data;
        end
    end

    assign bus.top_data  = w_empty ? '0 : r_mem[w_top_idx];
    assign bus.sp        = r_sp;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_unf;
endmodule

// File: tb/tb_call_stack_unit.sv
// Directed self-checking bench for call_stack_unit.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_call_stack_unit;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    call_stack_unit_if #(.DATA_W(16), .SP_W(5)) u_if ();

    call_stack_unit #(
        .DATA_W (16),
        .DEPTH  (16),
        .SP_W   (5)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply one operation for a single cycle, then return strobes to idle
    task automatic do_op(input logic p, input logic q, input logic [15:0] d, input logic c);
        u_if.push      = p;
        u_if.pop       = q;
        u_if.push_data = d;
        u_if.err_clr   = c;
        step();
        u_if.push      = 1'b0;
        u_if.pop       = 1'b0;
        u_if.err_clr   = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        u_if.push      = 1'b0;
        u_if.pop       = 1'b0;
        u_if.push_data = '0;
        u_if.err_clr   = 1'b0;
        #1;
        check_eq("rst_sp",    32'(u_if.sp),        32'd0);
        check_eq("rst_empty", 32'(u_if.empty),     32'd1);
        check_eq("rst_full",  32'(u_if.full),      32'd0);
        check_eq("rst_top",   32'(u_if.top_data),  32'h0);
        check_eq("rst_ovf",   32'(u_if.overflow),  32'd0);
        check_eq("rst_unf",   32'(u_if.underflow), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Asynchronous reset mid-stream
        for (int i = 1; i <= 3; i++) do_op(1'b1, 1'b0, 16'(i), 1'b0);
        check_eq("pre_rst_sp", 32'(u_if.sp), 32'd3);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_sp",    32'(u_if.sp),    32'd0);
        check_eq("async_rst_empty", 32'(u_if.empty), 32'd1);
        step();
        rst_n = 1'b1;
        step();

        // Push two, pop two
        do_op(1'b1, 1'b0, 16'h1234, 1'b0);
        do_op(1'b1, 1'b0, 16'hABCD, 1'b0);
        check_eq("pp_sp2",  32'(u_if.sp),       32'd2);
        check_eq("pp_top2", 32'(u_if.top_data), 32'hABCD);
        u_if.pop = 1'b1;
        #1;
        check_eq("pop_same_cycle_top", 32'(u_if.top_data), 32'hABCD);
        step();
        u_if.pop = 1'b0;
        check_eq("pop1_sp",  32'(u_if.sp),       32'd1);
        check_eq("pop1_top", 32'(u_if.top_data), 32'h1234);
        do_op(1'b0, 1'b1, 16'h0, 1'b0);
        check_eq("pop2_empty", 32'(u_if.empty),    32'd1);
        check_eq("pop2_top",   32'(u_if.top_data), 32'h0);

        // Fill, overflow, clear, replace when full
        for (int i = 0; i < 16; i++) do_op(1'b1, 1'b0, 16'(i), 1'b0);
        check_eq("fill_full", 32'(u_if.full),     32'd1);
        check_eq("fill_sp",   32'(u_if.sp),       32'd16);
        check_eq("fill_top",  32'(u_if.top_data), 32'h000F);
        do_op(1'b1, 1'b0, 16'hFFFF, 1'b0);
        check_eq("ovf_flag", 32'(u_if.overflow), 32'd1);
        check_eq("ovf_sp",   32'(u_if.sp),       32'd16);
        check_eq("ovf_top",  32'(u_if.top_data), 32'h000F);
        do_op(1'b0, 1'b0, 16'h0, 1'b1);
        check_eq("ovf_clr", 32'(u_if.overflow), 32'd0);
        do_op(1'b1, 1'b1, 16'hBEEF, 1'b0);
        check_eq("rep_full_sp",  32'(u_if.sp),       32'd16);
        check_eq("rep_full_top", 32'(u_if.top_data), 32'hBEEF);
        check_eq("rep_full_ovf", 32'(u_if.overflow), 32'd0);
        do_op(1'b0, 1'b1, 16'h0, 1'b0);
        check_eq("below_rep_top", 32'(u_if.top_data), 32'h000E);
        for (int i = 0; i < 15; i++) do_op(1'b0, 1'b1, 16'h0, 1'b0);
        check_eq("drain_sp", 32'(u_if.sp), 32'd0);

        // Underflow and set-wins-over-clear
        do_op(1'b0, 1'b1, 16'h0, 1'b0);
        check_eq("unf_flag", 32'(u_if.underflow), 32'd1);
        check_eq("unf_sp",   32'(u_if.sp),        32'd0);
        do_op(1'b0, 1'b1, 16'h0, 1'b1);
        check_eq("unf_set_wins", 32'(u_if.underflow), 32'd1);
        do_op(1'b0, 1'b0, 16'h0, 1'b1);
        check_eq("unf_clr", 32'(u_if.underflow), 32'd0);

        // Replace on empty behaves as push plus underflow
        do_op(1'b1, 1'b1, 16'h0055, 1'b0);
        check_eq("rep_empty_sp",  32'(u_if.sp),        32'd1);
        check_eq("rep_empty_top", 32'(u_if.top_data),  32'h0055);
        check_eq("rep_empty_unf", 32'(u_if.underflow), 32'd1);
        check_eq("rep_empty_ovf", 32'(u_if.overflow),  32'd0);
        do_op(1'b0, 1'b0, 16'h0, 1'b1);

        // Replace-top with sp=3
        do_op(1'b1, 1'b0, 16'h0002, 1'b0);
        do_op(1'b1, 1'b0, 16'h0003, 1'b0);
        check_eq("rep3_pre_top", 32'(u_if.top_data), 32'h0003);
        do_op(1'b1, 1'b1, 16'h00AA, 1'b0);
        check_eq("rep3_sp",  32'(u_if.sp),       32'd3);
        check_eq("rep3_top", 32'(u_if.top_data), 32'h00AA);
        for (int i = 0; i < 3; i++) do_op(1'b0, 1'b1, 16'h0, 1'b0);
        check_eq("rep3_drain_sp", 32'(u_if.sp), 32'd0);

        // JSR / POP round trip
        do_op(1'b1, 1'b0, 16'h0042, 1'b0);
        do_op(1'b1, 1'b0, 16'h7777, 1'b0);
        u_if.pop = 1'b1;
        #1;
        check_eq("jsr_pop1", 32'(u_if.top_data), 32'h7777);
        step();
        #1;
        check_eq("jsr_pop2", 32'(u_if.top_data), 32'h0042);
        step();
        u_if.pop = 1'b0;
        check_eq("jsr_sp",    32'(u_if.sp),        32'd0);
        check_eq("jsr_unf",   32'(u_if.underflow), 32'd0);
        check_eq("jsr_empty", 32'(u_if.empty),     32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
